// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite type definitions.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_state;

endpackage

// File: rtl/ahb3lite_mem_responder_if.sv
// AHB-Lite bus bundle between the DMA master and the memory responder.
interface ahb3lite_mem_responder_if;
  import ahb3lite_pkg::*;

  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  HTRANS_state HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb3lite_mem_responder.sv
// AHB-Lite slave memory model: single/burst transfers, programmable wait
// states, memory-side write port for completed writes.
// Optional feature macro AHB_MEM_ERRCHK_EN: non-word HSIZE or unaligned
// HADDR gets a two-cycle ERROR response; without it every accept is OKAY.
module ahb3lite_mem_responder
  import ahb3lite_pkg::*;
#(
  parameter int unsigned MEM_AW = 6
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  ahb3lite_mem_responder_if.slave   bus,
  input  logic [3:0]                wait_cfg,
  output logic                      mem_write_flag,
  output logic [31:0]               mem_WR_addr,
  output logic [31:0]               HWDATA_toMem
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA
`ifdef AHB_MEM_ERRCHK_EN
    , ST_ERR1,
    ST_ERR2
`endif
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [3:0]        wcnt;
  logic [31:0]       dp_addr;
  logic              dp_write;
  logic              hreadyout_q;
  logic              hreadyout_d;
  logic [31:0]       hrdata_q;
  logic [31:0]       mem [DEPTH];
  logic              accept;
  logic [MEM_AW-1:0] ap_idx;
  logic [MEM_AW-1:0] dp_idx;

  assign accept = bus.HSEL & bus.HREADY &
                  ((bus.HTRANS == NONSEQ) || (bus.HTRANS == SEQ));
  assign ap_idx = bus.HADDR[MEM_AW+1:2];
  assign dp_idx = dp_addr[MEM_AW+1:2];

`ifdef AHB_MEM_ERRCHK_EN
  logic illegal;
  logic hresp_q;
  logic hresp_d;

  assign illegal = (bus.HSIZE != 3'b010) || (bus.HADDR[1:0] != 2'b00);
`else
  logic unused_hsize;

  assign unused_hsize = ^bus.HSIZE;
`endif

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode: ST_IDLE, ST_DATA and ST_ERR2 all take a new accept
  always_comb begin
    state_n = ST_IDLE;
    case (state)
      ST_WAIT: state_n = (wcnt == 4'd1) ? ST_DATA : ST_WAIT;
`ifdef AHB_MEM_ERRCHK_EN
      ST_ERR1: state_n = ST_ERR2;
`endif
      default: begin
        if (accept) begin
`ifdef AHB_MEM_ERRCHK_EN
          if (illegal) begin
            state_n = ST_ERR1;
          end else
`endif
          if (wait_cfg == 4'd0) begin
            state_n = ST_DATA;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
    endcase
  end

  // Output decode: registered-response next values and the combinational write port
  always_comb begin
    hreadyout_d = 1'b1;
`ifdef AHB_MEM_ERRCHK_EN
    hresp_d     = 1'b0;
`endif
    case (state_n)
      ST_WAIT: hreadyout_d = 1'b0;
`ifdef AHB_MEM_ERRCHK_EN
      ST_ERR1: begin
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end
      ST_ERR2: hresp_d = 1'b1;
`endif
      default: hreadyout_d = 1'b1;
    endcase
    mem_write_flag = (state == ST_DATA) & dp_write & ~HRESET;
    HWDATA_toMem   = mem_write_flag ? bus.HWDATA : '0;
  end

  // Registered bus responses
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hreadyout_q <= 1'b1;
`ifdef AHB_MEM_ERRCHK_EN
      hresp_q     <= 1'b0;
`endif
    end else begin
      hreadyout_q <= hreadyout_d;
`ifdef AHB_MEM_ERRCHK_EN
      hresp_q     <= hresp_d;
`endif
    end
  end

  // Address-phase capture, wait-state countdown and read-data register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_addr  <= '0;
      dp_write <= 1'b0;
      wcnt     <= '0;
      hrdata_q <= '0;
    end else if (accept) begin
      dp_addr  <= bus.HADDR;
      dp_write <= bus.HWRITE;
      wcnt     <= wait_cfg;
      // a write landing on the same word at this edge is forwarded
      hrdata_q <= (mem_write_flag && (dp_idx == ap_idx)) ? bus.HWDATA : mem[ap_idx];
    end else if (state == ST_WAIT) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // Backing array; contents are deliberately not reset
  always_ff @(posedge HCLK) begin
    if (mem_write_flag) begin
      mem[dp_idx] <= bus.HWDATA;
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRDATA    = hrdata_q;
  assign mem_WR_addr   = dp_addr;
`ifdef AHB_MEM_ERRCHK_EN
  assign bus.HRESP     = hresp_q;
`else
  assign bus.HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb3lite_mem_responder.sv
// Self-checking bench for ahb3lite_mem_responder: directed test-plan steps
// followed by randomized traffic, all checked against a cycle-timeline
// reference model (expected events keyed by cycle number).
module tb_ahb3lite_mem_responder;
  import ahb3lite_pkg::*;

  localparam int unsigned MEM_AW = 6;
  localparam int unsigned DEPTH  = 1 << MEM_AW;
`ifdef AHB_MEM_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [3:0]  wait_cfg;
  logic        mem_write_flag;
  logic [31:0] mem_WR_addr;
  logic [31:0] HWDATA_toMem;
  int          cyc = 0;

  ahb3lite_mem_responder_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb3lite_mem_responder #(.MEM_AW(MEM_AW)) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .bus            (bus),
    .wait_cfg       (wait_cfg),
    .mem_write_flag (mem_write_flag),
    .mem_WR_addr    (mem_WR_addr),
    .HWDATA_toMem   (HWDATA_toMem)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    logic        sel;
    HTRANS_state trans;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic [3:0]  wt;
  } tr_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  tr_t         stim_q[$];
  bit          exp_low[int];
  bit          exp_err[int];
  wr_t         exp_wr[int];
  logic [31:0] exp_rd[int];
  logic [31:0] ref_mem[int];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_pulse  = 0;
  int          n_errcyc = 0;
  int          n_low    = 0;
  logic [31:0] dp_data  = '0;
  int          dp_acc   = -1;
  int          dp_done  = -1;
  int          last_busy = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit is_illegal(input tr_t t);
    return ERRCHK && ((t.size != 3'b010) || (t.addr % 4 != 0));
  endfunction

  function automatic tr_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] wt, input HTRANS_state tr);
    tr_t t;
    t.sel = 1'b1; t.trans = tr; t.wr = wr; t.addr = a; t.data = d;
    t.size = 3'b010; t.wt = wt;
    return t;
  endfunction

  // A bus cycle that must not start a transfer
  function automatic tr_t idle_tr();
    tr_t t;
    t.sel   = 1'($urandom_range(0, 1));
    t.trans = t.sel ? HTRANS_state'($urandom_range(0, 1)) : HTRANS_state'($urandom_range(0, 3));
    t.wr    = 1'($urandom_range(0, 1));
    t.addr  = $urandom;
    t.data  = $urandom;
    t.size  = 3'b010;
    t.wt    = 4'($urandom_range(0, 15));
    return t;
  endfunction

  task automatic drive_bus(input tr_t t);
    bus.HSEL   = t.sel;
    bus.HTRANS = t.trans;
    bus.HWRITE = t.wr;
    bus.HADDR  = t.addr;
    bus.HSIZE  = t.size;
    wait_cfg   = t.wt;
  endtask

  // Reference model: schedule the consequences of a transfer accepted in cycle c
  task automatic model_accept(input tr_t t, input int c);
    int done;
    if (is_illegal(t)) begin
      exp_low[c+1] = 1'b1;
      exp_err[c+1] = 1'b1;
      exp_err[c+2] = 1'b1;
      last_busy    = c + 2;
      return;
    end
    for (int k = 1; k <= int'(t.wt); k++) exp_low[c+k] = 1'b1;
    done      = c + 1 + int'(t.wt);
    last_busy = done;
    if (t.wr) begin
      exp_wr[done] = '{t.addr, t.data};
      dp_data = t.data;
      dp_acc  = c;
      dp_done = done;
    end else if (ref_mem.exists(widx(t.addr))) begin
      for (int k = c + 1; k <= done; k++) exp_rd[k] = ref_mem[widx(t.addr)];
    end
  endtask

  // One bus cycle, entered at the falling edge: drive, then check
  task automatic do_cycle(input bit rst);
    int  c;
    tr_t t;
    wr_t w;
    c = cyc;
    HRESET = rst;
    if (dp_acc >= 0 && c > dp_acc && c <= dp_done) bus.HWDATA = dp_data;
    else bus.HWDATA = $urandom;
    if (rst) begin
      exp_wr.delete(c);
      drive_bus(idle_tr());
    end else begin
      if (exp_wr.exists(c)) ref_mem[widx(exp_wr[c].addr)] = exp_wr[c].data;
      if (!exp_low.exists(c)) begin
        if (stim_q.size() > 0) t = stim_q.pop_front();
        else t = idle_tr();
        drive_bus(t);
        if (t.sel && (t.trans == NONSEQ || t.trans == SEQ)) model_accept(t, c);
      end else begin
        wait_cfg = 4'($urandom_range(0, 15));
      end
    end
    #1;
    chk("HREADYOUT", 32'(bus.HREADYOUT), exp_low.exists(c) ? 32'd0 : 32'd1);
    chk("HRESP", 32'(bus.HRESP), exp_err.exists(c) ? 32'd1 : 32'd0);
    chk("mem_write_flag", 32'(mem_write_flag), exp_wr.exists(c) ? 32'd1 : 32'd0);
    if (exp_wr.exists(c)) begin
      w = exp_wr[c];
      chk("mem_WR_addr", mem_WR_addr, w.addr);
      chk("HWDATA_toMem", HWDATA_toMem, w.data);
    end else begin
      chk("HWDATA_toMem_idle", HWDATA_toMem, 32'd0);
    end
    if (exp_rd.exists(c)) chk("HRDATA", bus.HRDATA, exp_rd[c]);
    if (mem_write_flag === 1'b1) n_pulse++;
    if (bus.HRESP === 1'b1) n_errcyc++;
    if (bus.HREADYOUT === 1'b0) n_low++;
    if (rst) begin
      exp_low.delete(); exp_err.delete(); exp_wr.delete(); exp_rd.delete();
      dp_acc = -1; dp_done = -1; last_busy = -1;
    end
  endtask

  task automatic run(input int budget);
    int spent;
    spent = 0;
    while ((stim_q.size() > 0 || cyc <= last_busy) && spent < budget) begin
      @(negedge HCLK);
      do_cycle(1'b0);
      spent++;
    end
    chk("run_budget", 32'(spent < budget), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0;
    int          e0;
    int          l0;
    tr_t         t;
    int          kind;
    int unsigned word;
    int unsigned alias_n;

    drive_bus(idle_tr());
    bus.HWDATA = '0;
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);

    // reset state on an idle bus
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      do_cycle(1'b0);
      chk("idle_HRDATA", bus.HRDATA, 32'd0);
      chk("idle_flag", 32'(mem_write_flag), 32'd0);
    end

    // zero-wait 4-word burst
    p0 = n_pulse;
    for (int i = 0; i < 4; i++)
      stim_q.push_back(mk(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'd0, (i == 0) ? NONSEQ : SEQ));
    run(50);
    chk("burst_pulses", 32'(n_pulse - p0), 32'd4);

    // single write with three wait states
    p0 = n_pulse; l0 = n_low;
    stim_q.push_back(mk(1'b1, 32'h200, 32'hCAFE_0003, 4'd3, NONSEQ));
    run(50);
    chk("wait3_low_cycles", 32'(n_low - l0), 32'd3);
    chk("wait3_pulses", 32'(n_pulse - p0), 32'd1);

    // read-after-write forwarding
    stim_q.push_back(mk(1'b1, 32'h40, 32'hDEAD_BEEF, 4'd0, NONSEQ));
    run(50);
    stim_q.push_back(mk(1'b1, 32'h40, 32'h1234_5678, 4'd0, NONSEQ));
    stim_q.push_back(mk(1'b0, 32'h40, 32'h0, 4'd0, NONSEQ));
    run(50);
    chk("fwd_hrdata", bus.HRDATA, 32'h1234_5678);

    // unaligned write
    p0 = n_pulse; e0 = n_errcyc;
    stim_q.push_back(mk(1'b1, 32'h42, 32'h55AA_55AA, 4'd0, NONSEQ));
    run(50);
    chk("unaligned_pulses", 32'(n_pulse - p0), ERRCHK ? 32'd0 : 32'd1);
    chk("unaligned_err_cycles", 32'(n_errcyc - e0), ERRCHK ? 32'd2 : 32'd0);

    // reset during the wait states of a write
    stim_q.push_back(mk(1'b1, 32'h80, 32'h1111_1111, 4'd0, NONSEQ));
    run(50);
    stim_q.push_back(mk(1'b1, 32'h80, 32'h2222_2222, 4'd5, NONSEQ));
    p0 = n_pulse;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      do_cycle(1'b0);
    end
    @(negedge HCLK);
    do_cycle(1'b1);
    @(negedge HCLK);
    do_cycle(1'b0);
    chk("rst_HREADYOUT", 32'(bus.HREADYOUT), 32'd1);
    chk("rst_HRESP", 32'(bus.HRESP), 32'd0);
    chk("rst_HRDATA", bus.HRDATA, 32'd0);
    chk("rst_mem_WR_addr", mem_WR_addr, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      do_cycle(1'b0);
    end
    chk("rst_wait_pulses", 32'(n_pulse - p0), 32'd0);
    stim_q.push_back(mk(1'b0, 32'h80, 32'h0, 4'd1, NONSEQ));
    run(50);
    chk("rst_wait_mem_kept", bus.HRDATA, 32'h1111_1111);

    // reset in the data cycle of a write
    stim_q.push_back(mk(1'b1, 32'h84, 32'h3333_3333, 4'd0, NONSEQ));
    run(50);
    stim_q.push_back(mk(1'b1, 32'h84, 32'h4444_4444, 4'd2, NONSEQ));
    p0 = n_pulse;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      do_cycle(1'b0);
    end
    @(negedge HCLK);
    do_cycle(1'b1);
    @(negedge HCLK);
    do_cycle(1'b0);
    chk("rst_data_pulses", 32'(n_pulse - p0), 32'd0);
    stim_q.push_back(mk(1'b0, 32'h84, 32'h0, 4'd0, NONSEQ));
    run(50);
    chk("rst_data_mem_kept", bus.HRDATA, 32'h3333_3333);

    // randomized traffic, aliased addresses, occasional illegal transfers
    for (int i = 0; i < 300; i++) begin
      kind    = $urandom_range(0, 9);
      word    = $urandom_range(0, DEPTH - 1);
      alias_n = $urandom_range(0, 3);
      if (kind == 0) begin
        t = idle_tr();
      end else begin
        t = mk(kind <= 4, 32'(alias_n * DEPTH * 4 + word * 4), $urandom,
               4'($urandom_range(0, 3)), $urandom_range(0, 1) ? NONSEQ : SEQ);
        if ($urandom_range(0, 19) == 0) t.wt = 4'd15;
        if ($urandom_range(0, 15) == 0) t.size = 3'b001;
        if ($urandom_range(0, 15) == 0) t.addr = t.addr + 32'd2;
      end
      stim_q.push_back(t);
    end
    run(8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
